alu_frame_ctrl: RTL and testbench
=================================

Name: alu_frame_ctrl

Overview:
- Framed-command sequencer between the UART core FIFOs and the ALU.
- Pops a 5-byte command frame from the RX FIFO and validates its sync byte, opcode range and checksum.
- On a valid frame: loads the ALU operand/opcode registers, captures the result, then pushes a 4-byte response frame into the TX FIFO.
- Adds framing, error reporting and inter-byte timeout on top of the existing raw byte-stream link.

Parameters:
- NB_DATA, 8, UART byte / ALU operand width
- NB_OPCODE, 6, ALU opcode width
- SYNC_BYTE, 8'hA5, frame start marker for both command and response frames
- TIMEOUT_CYCLES, 100000, max idle cycles between command bytes
- NB_TIMEOUT, 17, timeout counter width

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-low reset
- i_rx_empty  in  1  RX FIFO empty flag
- i_rx_data  in  NB_DATA  RX FIFO head byte (first-word-fall-through)
- o_rx_read  out  1  RX pop strobe
- i_tx_full  in  1  TX FIFO full flag
- o_tx_data  out  NB_DATA  byte to push
- o_tx_write  out  1  TX push strobe
- i_alu_result  in  NB_DATA  ALU combinational result
- o_alu_opcode  out  NB_OPCODE  registered ALU opcode
- o_alu_op_A  out  NB_DATA  registered operand A
- o_alu_op_B  out  NB_DATA  registered operand B
- o_busy  out  1  high whenever state != IDLE
- o_err_count  out  8  saturating count of rejected frames

Behaviour:
- Reset (i_reset low, asynchronous):
  - state=IDLE; all outputs 0.
  - Shadow registers, result register, timeout counter and byte index cleared.
- Command frame: SYNC, OPC, A, B, CHK, where CHK = OPC ^ A ^ B.
- Response frame: SYNC, STATUS, RESULT, RCHK, where RCHK = STATUS ^ RESULT.
  - STATUS: 0x00 ok, 0x01 checksum error, 0x02 opcode error (OPC[7:NB_OPCODE] != 0), 0x03 both.
  - RESULT is 0x00 on any error.
- RX handshake:
  - o_rx_read is a 1-cycle pulse, asserted only when i_rx_empty=0 in a receive state.
  - i_rx_data is sampled on the same edge; at most one pop per cycle.
  - o_rx_read is never asserted while i_rx_empty=1.
- TX handshake:
  - o_tx_write is a 1-cycle pulse with o_tx_data valid in the same cycle.
  - Asserted only when i_tx_full=0; while full, SEND stalls with the byte index held.
- States:
  - IDLE: pop every available byte. SYNC_BYTE -> GET_OPC; any other byte is discarded, stay in IDLE.
  - GET_OPC / GET_A / GET_B: pop one byte into the shadow register, advance to the next state.
  - A SYNC_BYTE value received in these states is treated as data (no resync).
  - GET_CHK: pop CHK and compute STATUS.
    - STATUS=0: copy shadow OPC[NB_OPCODE-1:0]/A/B into o_alu_* registers -> EXEC.
    - STATUS!=0: o_alu_* unchanged, increment o_err_count -> SEND.
  - EXEC: exactly one cycle; latch i_alu_result into the result register -> SEND.
  - SEND: emit bytes 0..3 in order; after byte 3 is written -> IDLE.
- Timing: CHK popped at edge k -> EXEC during cycle k+1 -> first o_tx_write in cycle k+2 if not full. The four bytes go out in consecutive cycles when the TX FIFO never fills.
- Timeout (GET_OPC..GET_CHK only):
  - Counter clears on every pop and increments each cycle with i_rx_empty=1.
  - At TIMEOUT_CYCLES-1: increment o_err_count -> IDLE. No response is sent.
  - Counter is held at 0 outside the receive states.
- o_err_count saturates at 255; it never wraps.
- o_alu_* registers hold their value between frames; the ALU sees them continuously.
- Reset mid-frame or mid-SEND aborts immediately. No partial response is resumed after reset release.

Test Plan:
- Frame A5 20 05 03 26 with the ALU instance (opcode 0x20 = ADD) -> o_alu_op_A=05, o_alu_op_B=03; TX receives A5 00 08 08; o_err_count=0.
- Bytes 11 22 before A5 20 05 03 26 -> 11 and 22 popped and discarded; single response A5 00 08 08.
- Frame A5 20 05 03 27 (bad CHK) -> TX receives A5 01 00 01; o_err_count=1; o_alu_* unchanged from the prior frame.
- Frame A5 E0 05 03 E6 (opcode upper bits set, CHK correct) -> A5 02 00 02.
- Frame A5 20 05 03 26 with i_tx_full held high for 10 cycles after byte 1 -> bytes stall, no write while full, final byte order intact.
- A5 20 followed by TIMEOUT_CYCLES idle cycles -> return to IDLE, o_busy=0, o_err_count increments, no TX writes.
- Reset asserted mid-SEND -> all outputs 0 immediately; after release, a new valid frame produces one clean response.

Source files
------------

// File: rtl/alu_frame_ctrl.sv
// Framed-command sequencer: pops SYNC/OPC/A/B/CHK from the RX FIFO, drives the ALU
// operand registers and answers with SYNC/STATUS/RESULT/RCHK into the TX FIFO.
module alu_frame_ctrl #(
    parameter int                  NB_DATA        = 8,
    parameter int                  NB_OPCODE      = 6,
    parameter logic [NB_DATA-1:0]  SYNC_BYTE      = 8'hA5,
    parameter int                  TIMEOUT_CYCLES = 100000,
    parameter int                  NB_TIMEOUT     = 17
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx_empty,
    input  logic [NB_DATA-1:0]   i_rx_data,
    output logic                 o_rx_read,
    input  logic                 i_tx_full,
    output logic [NB_DATA-1:0]   o_tx_data,
    output logic                 o_tx_write,
    input  logic [NB_DATA-1:0]   i_alu_result,
    output logic [NB_OPCODE-1:0] o_alu_opcode,
    output logic [NB_DATA-1:0]   o_alu_op_A,
    output logic [NB_DATA-1:0]   o_alu_op_B,
    output logic                 o_busy,
    output logic [7:0]           o_err_count
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] GET_OPC = 3'd1;
    localparam logic [2:0] GET_A   = 3'd2;
    localparam logic [2:0] GET_B   = 3'd3;
    localparam logic [2:0] GET_CHK = 3'd4;
    localparam logic [2:0] EXEC    = 3'd5;
    localparam logic [2:0] SEND    = 3'd6;

    localparam logic [NB_TIMEOUT-1:0] TMO_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

    logic [2:0]            state;
    logic [NB_DATA-1:0]    sh_opc, sh_a, sh_b;
    logic [NB_DATA-1:0]    status, result;
    logic [NB_DATA-1:0]    status_nxt;
    logic [1:0]            byte_idx;
    logic [NB_TIMEOUT-1:0] tmo_cnt;
    logic                  in_frame;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign in_frame   = (state == GET_OPC) || (state == GET_A) ||
                        (state == GET_B)   || (state == GET_CHK);
    // Reset gating keeps the pop strobe low while IDLE is held in reset.
    assign o_rx_read  = i_reset && ((state == IDLE) || in_frame) && !i_rx_empty;
    assign o_tx_write = (state == SEND) && !i_tx_full;
    assign o_busy     = (state != IDLE);

    always_comb begin
        status_nxt    = '0;
        status_nxt[0] = ((sh_opc ^ sh_a ^ sh_b) != i_rx_data);
        status_nxt[1] = |sh_opc[NB_DATA-1:NB_OPCODE];
    end

    always_comb begin
        o_tx_data = '0;
        if (state == SEND) begin
            case (byte_idx)
                2'd0:    o_tx_data = SYNC_BYTE;
                2'd1:    o_tx_data = status;
                2'd2:    o_tx_data = result;
                default: o_tx_data = status ^ result;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state        <= IDLE;
            sh_opc       <= '0;
            sh_a         <= '0;
            sh_b         <= '0;
            status       <= '0;
            result       <= '0;
            byte_idx     <= '0;
            tmo_cnt      <= '0;
            o_alu_opcode <= '0;
            o_alu_op_A   <= '0;
            o_alu_op_B   <= '0;
            o_err_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (o_rx_read && i_rx_data == SYNC_BYTE) state <= GET_OPC;
                end
                GET_OPC, GET_A, GET_B, GET_CHK: begin
                    if (o_rx_read) begin
                        tmo_cnt <= '0;
                        case (state)
                            GET_OPC: begin sh_opc <= i_rx_data; state <= GET_A; end
                            GET_A:   begin sh_a   <= i_rx_data; state <= GET_B; end
                            GET_B:   begin sh_b   <= i_rx_data; state <= GET_CHK; end
                            default: begin
                                status   <= status_nxt;
                                byte_idx <= '0;
                                if (status_nxt == '0) begin
                                    o_alu_opcode <= sh_opc[NB_OPCODE-1:0];
                                    o_alu_op_A   <= sh_a;
                                    o_alu_op_B   <= sh_b;
                                    state        <= EXEC;
                                end else begin
                                    result      <= '0;
                                    o_err_count <= sat_inc(o_err_count);
                                    state       <= SEND;
                                end
                            end
                        endcase
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Stalled frame is dropped silently apart from the error count.
                        tmo_cnt     <= '0;
                        o_err_count <= sat_inc(o_err_count);
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + NB_TIMEOUT'(1);
                    end
                end
                EXEC: begin
                    result <= i_alu_result;
                    state  <= SEND;
                end
                SEND: begin
                    if (o_tx_write) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_frame_ctrl.sv
// Bench for alu_frame_ctrl: FIFO models around the DUT, a small ALU, and a frame-level
// reference that predicts each response, error count and operand registers.
module tb_alu_frame_ctrl;

    localparam int TMO = 40;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_rx_empty = 1'b1;
    logic [7:0] i_rx_data = 8'h00;
    logic       o_rx_read;
    logic       i_tx_full = 1'b0;
    logic [7:0] o_tx_data;
    logic       o_tx_write;
    logic [7:0] i_alu_result;
    logic [5:0] o_alu_opcode;
    logic [7:0] o_alu_op_A, o_alu_op_B;
    logic       o_busy;
    logic [7:0] o_err_count;

    alu_frame_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_rx_empty(i_rx_empty), .i_rx_data(i_rx_data), .o_rx_read(o_rx_read),
        .i_tx_full(i_tx_full), .o_tx_data(o_tx_data), .o_tx_write(o_tx_write),
        .i_alu_result(i_alu_result), .o_alu_opcode(o_alu_opcode),
        .o_alu_op_A(o_alu_op_A), .o_alu_op_B(o_alu_op_B),
        .o_busy(o_busy), .o_err_count(o_err_count)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] alu_ref(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h02:   return a >> b[2:0];
            default: return 8'h00;
        endcase
    endfunction

    assign i_alu_result = alu_ref(o_alu_opcode, o_alu_op_A, o_alu_op_B);

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int rd_viol = 0, wr_viol = 0;
    int n_pass = 0, n_total = 0;
    bit rand_full = 0;

    always @(posedge i_clk) begin
        if (o_rx_read && i_rx_empty) rd_viol++;
        if (o_tx_write && i_tx_full) wr_viol++;
        if (o_rx_read && rx_q.size() > 0) void'(rx_q.pop_front());
        if (o_tx_write) tx_q.push_back(o_tx_data);
    end

    always @(negedge i_clk) begin
        i_rx_empty = (rx_q.size() == 0);
        i_rx_data  = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
    end

    // Frame-level expectations
    logic [5:0] m_op = '0;
    logic [7:0] m_a = '0, m_b = '0;
    int         m_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ex);
        n_total++;
        assert (obs === ex) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, ex);
    endtask

    task automatic run_frame(input logic [7:0] opc, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] chk_b, input bit stall, input string tag);
        logic [7:0] st, res;
        logic [7:0] ex[4];
        int c;
        st = 8'h00;
        if (opc[7:6] != 2'b00) st = st | 8'h02;
        if ((opc ^ a ^ b) != chk_b) st = st | 8'h01;
        res = (st == 8'h00) ? alu_ref(opc[5:0], a, b) : 8'h00;
        ex = '{SYNC, st, res, st ^ res};
        if (st == 8'h00) begin m_op = opc[5:0]; m_a = a; m_b = b; end
        else if (m_err < 255) m_err++;
        rx_q.push_back(SYNC); rx_q.push_back(opc); rx_q.push_back(a);
        rx_q.push_back(b);    rx_q.push_back(chk_b);
        c = 0;
        while (tx_q.size() < 4 && c < 300) begin
            @(negedge i_clk);
            c++;
            i_tx_full = rand_full ? ($urandom_range(0, 2) == 0) : 1'b0;
            if (stall && tx_q.size() == 1) begin
                i_tx_full = 1'b1;
                repeat (10) @(negedge i_clk);
                chk({tag, "_stall_hold"}, tx_q.size(), 1);
                i_tx_full = 1'b0;
                stall = 0;
            end
        end
        i_tx_full = 1'b0;
        repeat (3) @(negedge i_clk);
        chk({tag, "_tx_count"}, tx_q.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_byte%0d", tag, i), (i < tx_q.size()) ? tx_q[i] : 8'hxx, ex[i]);
        chk({tag, "_err"}, o_err_count, m_err);
        chk({tag, "_opc"}, o_alu_opcode, m_op);
        chk({tag, "_a"},   o_alu_op_A, m_a);
        chk({tag, "_b"},   o_alu_op_B, m_b);
        chk({tag, "_busy"}, o_busy, 0);
        tx_q.delete();
    endtask

    initial begin : stim
        logic [7:0] opc, a, b, ck;
        int c;
        logic [5:0] ops[7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02};

        // Reset state
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_rx_read", o_rx_read, 0);
        chk("rst_tx_write", o_tx_write, 0);
        chk("rst_err", o_err_count, 0);
        chk("rst_alu", {o_alu_opcode, o_alu_op_A, o_alu_op_B}, 0);
        repeat (2) @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);

        run_frame(8'h20, 8'h05, 8'h03, 8'h26, 0, "add");
        rx_q.push_back(8'h11); rx_q.push_back(8'h22);
        run_frame(8'h20, 8'h05, 8'h03, 8'h26, 0, "garbage");
        run_frame(8'h20, 8'h05, 8'h03, 8'h27, 0, "badchk");
        run_frame(8'hE0, 8'h05, 8'h03, 8'hE6, 0, "badopc");
        run_frame(8'h20, 8'h05, 8'h03, 8'h26, 1, "stall");

        // Inter-byte timeout after SYNC/OPC
        rx_q.push_back(SYNC); rx_q.push_back(8'h20);
        c = 0;
        while (rx_q.size() != 0 && c < 50) begin @(negedge i_clk); c++; end
        chk("tmo_busy_before", o_busy, 1);
        c = 0;
        while (o_busy && c < TMO + 20) begin @(negedge i_clk); c++; end
        chk("tmo_cycles", c, TMO);
        if (m_err < 255) m_err++;
        chk("tmo_busy_after", o_busy, 0);
        chk("tmo_err", o_err_count, m_err);
        chk("tmo_no_tx", tx_q.size(), 0);

        // Randomized frames, including SYNC values as payload
        for (int n = 0; n < 30; n++) begin
            opc = {2'b00, ops[$urandom_range(0, 6)]};
            if ($urandom_range(0, 4) == 0) opc[7:6] = 2'($urandom_range(1, 3));
            a = 8'($urandom); b = 8'($urandom);
            if (n % 7 == 3) a = SYNC;
            ck = opc ^ a ^ b;
            if ($urandom_range(0, 4) == 0) ck = ck ^ 8'($urandom_range(1, 255));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                logic [7:0] gb;
                gb = 8'($urandom);
                rx_q.push_back(gb == SYNC ? 8'h5A : gb);
            end
            rand_full = $urandom_range(0, 1);
            run_frame(opc, a, b, ck, 0, $sformatf("rnd%0d", n));
        end
        rand_full = 0;

        // Reset in the middle of a response
        rx_q.push_back(SYNC); rx_q.push_back(8'h20); rx_q.push_back(8'h07);
        rx_q.push_back(8'h01); rx_q.push_back(8'h26);
        c = 0;
        while (tx_q.size() < 2 && c < 100) begin @(negedge i_clk); c++; end
        i_reset = 1'b0;
        #1;
        chk("midrst_tx_write", o_tx_write, 0);
        chk("midrst_tx_data", o_tx_data, 0);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_regs", {o_alu_opcode, o_alu_op_A, o_alu_op_B, o_err_count}, 0);
        @(negedge i_clk);
        rx_q.delete();
        i_reset = 1'b1;
        tx_q.delete();
        m_op = '0; m_a = '0; m_b = '0; m_err = 0;
        run_frame(8'h22, 8'h09, 8'h04, 8'h22 ^ 8'h09 ^ 8'h04, 0, "postrst");

        // Error counter saturation
        for (int n = 0; n < 258; n++) begin
            if (m_err < 255) m_err++;
            rx_q.push_back(SYNC); rx_q.push_back(8'h20); rx_q.push_back(8'h01);
            rx_q.push_back(8'h02); rx_q.push_back(8'h00);
            c = 0;
            while (tx_q.size() < 4 && c < 100) begin @(negedge i_clk); c++; end
            tx_q.delete();
        end
        repeat (3) @(negedge i_clk);
        chk("sat_err", o_err_count, 255);
        chk("sat_model", m_err, 255);

        chk("rx_pop_while_empty", rd_viol, 0);
        chk("tx_push_while_full", wr_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
